// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer
// Brief    : Strobe-protocol initiator for register-file reads/writebacks,
//            with a 32-entry lock scoreboard blocking RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [4:0]           dec_raddr_a_i,
    input  logic [4:0]           dec_raddr_b_i,
    input  logic                 dec_use_a_i,
    input  logic                 dec_use_b_i,
    input  logic [4:0]           dec_waddr_i,
    input  logic                 dec_we_i,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output logic [DataWidth-1:0] op_a_o,
    output logic [DataWidth-1:0] op_b_o,
    output logic                 rf_en_r_o,
    output logic                 rf_req_ra_o,
    output logic                 rf_req_rb_o,
    output logic [4:0]           rf_raddr_a_o,
    output logic [4:0]           rf_raddr_b_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic                 rf_en_w_o,
    output logic                 rf_req_w_o,
    output logic [4:0]           rf_waddr_o,
    output logic                 rf_soursel_o,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    input  logic                 wb_src_alu_i,
    output logic                 wb_ready_o
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_RD_SETUP  = 3'd1;
    localparam logic [2:0] c_RD_STROBE = 3'd2;
    localparam logic [2:0] c_OP_HOLD   = 3'd3;
    localparam logic [2:0] c_WR_SETUP  = 3'd4;
    localparam logic [2:0] c_WR_STROBE = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [31:0]          r_lock;
    logic [4:0]           r_raddr_a;
    logic [4:0]           r_raddr_b;
    logic                 r_use_a;
    logic                 r_use_b;
    logic [4:0]           r_wb_addr;
    logic                 r_wb_src;
    logic [DataWidth-1:0] r_op_a;
    logic [DataWidth-1:0] r_op_b;
    logic                 r_en_r;
    logic                 r_req_ra;
    logic                 r_req_rb;
    logic                 r_en_w;
    logic                 r_req_w;
    logic                 r_wb_ready;
    logic                 r_op_valid;

    logic                 w_hazard;
    logic                 w_dec_ready;
    logic                 w_accept;
    logic                 w_wb_take;
    logic                 w_use_a_n;
    logic                 w_use_b_n;
    logic [4:0]           w_wb_addr_n;
    logic                 w_en_r_d;
    logic                 w_req_ra_d;
    logic                 w_req_rb_d;
    logic                 w_en_w_d;
    logic                 w_req_w_d;
    logic                 w_wb_ready_d;
    logic                 w_op_valid_d;

    assign w_hazard = (dec_use_a_i && (dec_raddr_a_i != 5'd0) && r_lock[dec_raddr_a_i])
                   || (dec_use_b_i && (dec_raddr_b_i != 5'd0) && r_lock[dec_raddr_b_i])
                   || (dec_we_i    && (dec_waddr_i   != 5'd0) && r_lock[dec_waddr_i]);

    // Gated by reset so the handshake output also reads 0 while held in reset.
    assign w_dec_ready = rst_ni && (r_state == c_IDLE) && !wb_valid_i && !w_hazard;
    assign w_accept    = dec_valid_i && w_dec_ready;
    assign w_wb_take   = (r_state == c_IDLE) && wb_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_wb_take) begin
                    w_state_next = c_WR_SETUP;
                end else if (w_accept) begin
                    w_state_next = (dec_use_a_i || dec_use_b_i) ? c_RD_SETUP : c_OP_HOLD;
                end
            end
            c_RD_SETUP:  w_state_next = c_RD_STROBE;
            c_RD_STROBE: w_state_next = c_OP_HOLD;
            c_OP_HOLD:   w_state_next = op_ready_i ? c_IDLE : c_OP_HOLD;
            c_WR_SETUP:  w_state_next = c_WR_STROBE;
            c_WR_STROBE: w_state_next = c_IDLE;
            default:     w_state_next = c_IDLE;
        endcase
    end

    // Strobe/request flops are loaded from the upcoming state so each pin is a clean flop output.
    assign w_use_a_n   = w_accept  ? dec_use_a_i : r_use_a;
    assign w_use_b_n   = w_accept  ? dec_use_b_i : r_use_b;
    assign w_wb_addr_n = w_wb_take ? wb_addr_i   : r_wb_addr;

    always_comb begin
        w_en_r_d     = 1'b0;
        w_req_ra_d   = 1'b0;
        w_req_rb_d   = 1'b0;
        w_en_w_d     = 1'b0;
        w_req_w_d    = 1'b0;
        w_wb_ready_d = 1'b0;
        w_op_valid_d = 1'b0;
        case (w_state_next)
            c_RD_SETUP: begin
                w_req_ra_d = w_use_a_n;
                w_req_rb_d = w_use_b_n;
            end
            c_RD_STROBE: begin
                w_en_r_d   = 1'b1;
                w_req_ra_d = w_use_a_n;
                w_req_rb_d = w_use_b_n;
            end
            c_OP_HOLD: w_op_valid_d = 1'b1;
            c_WR_SETUP: w_req_w_d = (w_wb_addr_n != 5'd0);
            c_WR_STROBE: begin
                w_req_w_d    = (w_wb_addr_n != 5'd0);
                w_en_w_d     = 1'b1;
                w_wb_ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en_r     <= 1'b0;
            r_req_ra   <= 1'b0;
            r_req_rb   <= 1'b0;
            r_en_w     <= 1'b0;
            r_req_w    <= 1'b0;
            r_wb_ready <= 1'b0;
            r_op_valid <= 1'b0;
        end else begin
            r_en_r     <= w_en_r_d;
            r_req_ra   <= w_req_ra_d;
            r_req_rb   <= w_req_rb_d;
            r_en_w     <= w_en_w_d;
            r_req_w    <= w_req_w_d;
            r_wb_ready <= w_wb_ready_d;
            r_op_valid <= w_op_valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock    <= '0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_use_a   <= 1'b0;
            r_use_b   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_src  <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
        end else begin
            if (w_wb_take) begin
                r_wb_addr <= wb_addr_i;
                r_wb_src  <= wb_src_alu_i;
            end
            if (w_accept) begin
                r_raddr_a <= dec_raddr_a_i;
                r_raddr_b <= dec_raddr_b_i;
                r_use_a   <= dec_use_a_i;
                r_use_b   <= dec_use_b_i;
                r_op_a    <= '0;
                r_op_b    <= '0;
                if (dec_we_i && (dec_waddr_i != 5'd0)) begin
                    r_lock[dec_waddr_i] <= 1'b1;
                end
            end
            if (r_state == c_RD_STROBE) begin
                r_op_a <= (r_use_a && (r_raddr_a != 5'd0)) ? rf_rdata_a_i : '0;
                r_op_b <= (r_use_b && (r_raddr_b != 5'd0)) ? rf_rdata_b_i : '0;
            end
            if (r_state == c_WR_STROBE) begin
                r_lock[r_wb_addr] <= 1'b0;
            end
        end
    end

    assign dec_ready_o  = w_dec_ready;
    assign op_valid_o   = r_op_valid;
    assign op_a_o       = r_op_a;
    assign op_b_o       = r_op_b;
    assign rf_en_r_o    = r_en_r;
    assign rf_req_ra_o  = r_req_ra;
    assign rf_req_rb_o  = r_req_rb;
    assign rf_raddr_a_o = r_raddr_a;
    assign rf_raddr_b_o = r_raddr_b;
    assign rf_en_w_o    = r_en_w;
    assign rf_req_w_o   = r_req_w;
    assign rf_waddr_o   = r_wb_addr;
    assign rf_soursel_o = r_wb_src;
    assign wb_ready_o   = r_wb_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sequencer
// Brief    : Directed bench with a register-file model and a cycle-timed
//            behavioural model of the sequencer checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready_o;
    logic [4:0]  dec_ra = '0, dec_rb = '0, dec_wd = '0;
    logic        dec_ua = 1'b0, dec_ub = 1'b0, dec_we = 1'b0;
    logic        op_valid_o;
    logic        op_ready = 1'b1;
    logic [31:0] op_a_o, op_b_o;
    logic        rf_en_r_o, rf_req_ra_o, rf_req_rb_o;
    logic [4:0]  rf_raddr_a_o, rf_raddr_b_o;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        rf_en_w_o, rf_req_w_o, rf_soursel_o;
    logic [4:0]  rf_waddr_o;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        wb_src = 1'b0;
    logic        wb_ready_o;

    logic [31:0] mem [32];
    logic [31:0] alu_data = '0, lsu_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.DataWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready_o),
        .dec_raddr_a_i(dec_ra), .dec_raddr_b_i(dec_rb),
        .dec_use_a_i(dec_ua), .dec_use_b_i(dec_ub),
        .dec_waddr_i(dec_wd), .dec_we_i(dec_we),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready),
        .op_a_o(op_a_o), .op_b_o(op_b_o),
        .rf_en_r_o(rf_en_r_o), .rf_req_ra_o(rf_req_ra_o), .rf_req_rb_o(rf_req_rb_o),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
        .rf_en_w_o(rf_en_w_o), .rf_req_w_o(rf_req_w_o),
        .rf_waddr_o(rf_waddr_o), .rf_soursel_o(rf_soursel_o),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_src_alu_i(wb_src),
        .wb_ready_o(wb_ready_o)
    );

    // Register file: x0 deliberately holds a non-zero pattern.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = i * 32'h0101_0101;
        mem[0] = 32'hFFFF_FFFF;
        mem[5] = 32'h0000_0011;
        mem[6] = 32'h0000_0022;
        forever begin
            @(posedge rf_en_w_o);
            if (rf_req_w_o) mem[rf_waddr_o] = rf_soursel_o ? alu_data : lsu_data;
        end
    end

    always @(posedge rf_en_r_o) begin
        rf_rdata_a = rf_req_ra_o ? mem[rf_raddr_a_o] : 32'hDEAD_BEEF;
        rf_rdata_b = rf_req_rb_o ? mem[rf_raddr_b_o] : 32'hDEAD_BEEF;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks when each transaction's events must appear.
    logic [31:0] m_lock;
    bit          m_hold;
    int          m_free, m_hold_from, m_enr, m_wbr;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_ra, m_rb, m_wa;
    logic        m_ua, m_ub, m_src;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_dec_ready", dec_ready_o, 1'b0);
            chk1("rst_op_valid", op_valid_o, 1'b0);
            chk1("rst_en_r", rf_en_r_o, 1'b0);
            chk1("rst_req_r", rf_req_ra_o | rf_req_rb_o, 1'b0);
            chk1("rst_en_w", rf_en_w_o, 1'b0);
            chk1("rst_req_w", rf_req_w_o, 1'b0);
            chk1("rst_wb_ready", wb_ready_o, 1'b0);
            chk32("rst_op_a", op_a_o, 32'h0);
            m_lock = '0; m_hold = 0; m_free = 0; m_hold_from = 0;
            m_enr = -10; m_wbr = -10;
        end else begin : model
            bit idle, hz, exp_rdy, opv;
            idle = !m_hold && (cyc >= m_free);
            hz = (dec_ua && dec_ra != 0 && m_lock[dec_ra]) ||
                 (dec_ub && dec_rb != 0 && m_lock[dec_rb]) ||
                 (dec_we && dec_wd != 0 && m_lock[dec_wd]);
            exp_rdy = idle && !wb_valid && !hz;
            opv = m_hold && (cyc >= m_hold_from);
            chk1("dec_ready", dec_ready_o, exp_rdy);
            chk1("op_valid", op_valid_o, opv);
            chk1("en_r", rf_en_r_o, cyc == m_enr);
            chk1("en_w", rf_en_w_o, cyc == m_wbr);
            chk1("wb_ready", wb_ready_o, cyc == m_wbr);
            if (opv) begin
                chk32("op_a", op_a_o, m_a);
                chk32("op_b", op_b_o, m_b);
            end
            if (cyc == m_enr) begin
                chk1("req_ra", rf_req_ra_o, m_ua);
                chk1("req_rb", rf_req_rb_o, m_ub);
                if (m_ua) chk32("raddr_a", {27'b0, rf_raddr_a_o}, {27'b0, m_ra});
                if (m_ub) chk32("raddr_b", {27'b0, rf_raddr_b_o}, {27'b0, m_rb});
            end
            if (cyc == m_wbr) begin
                chk32("waddr", {27'b0, rf_waddr_o}, {27'b0, m_wa});
                chk1("req_w", rf_req_w_o, m_wa != 0);
                chk1("soursel", rf_soursel_o, m_src);
                m_lock[m_wa] = 1'b0;
            end
            if (opv && op_ready) begin
                m_hold = 0;
                m_free = cyc + 1;
            end else if (idle && wb_valid) begin
                m_wa = wb_addr; m_src = wb_src;
                m_wbr = cyc + 2;
                m_free = cyc + 3;
            end else if (idle && dec_valid && exp_rdy) begin
                m_ra = dec_ra; m_rb = dec_rb; m_ua = dec_ua; m_ub = dec_ub;
                m_a = (dec_ua && dec_ra != 0) ? mem[dec_ra] : 32'h0;
                m_b = (dec_ub && dec_rb != 0) ? mem[dec_rb] : 32'h0;
                if (dec_we && dec_wd != 0) m_lock[dec_wd] = 1'b1;
                m_hold = 1;
                if (dec_ua || dec_ub) begin
                    m_enr = cyc + 2;
                    m_hold_from = cyc + 3;
                end else begin
                    m_hold_from = cyc + 1;
                end
            end
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_decode(input logic [4:0] ra, input logic [4:0] rb, input logic ua,
                             input logic ub, input logic [4:0] wd, input logic we,
                             output int waits);
        dec_ra = ra; dec_rb = rb; dec_ua = ua; dec_ub = ub; dec_wd = wd; dec_we = we;
        dec_valid = 1'b1;
        waits = 0;
        while (waits < 40) begin
            @(negedge clk);
            if (dec_ready_o) break;
            waits++;
        end
        if (waits >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL decode_timeout: dec_ready never rose within 40 cycles");
        end
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] addr, input logic alu, input logic [31:0] data,
                         input logic exp_req, output int waits);
        wb_addr = addr; wb_src = alu;
        if (alu) alu_data = data; else lsu_data = data;
        wb_valid = 1'b1;
        waits = 0;
        while (waits < 40) begin
            @(negedge clk);
            if (wb_ready_o) break;
            waits++;
        end
        if (waits >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL wb_timeout: wb_ready never pulsed within 40 cycles");
        end else begin
            chk1("wb_req_w_lit", rf_req_w_o, exp_req);
        end
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_opv(output int waits);
        waits = 0;
        while (waits < 40) begin
            @(negedge clk);
            if (op_valid_o) break;
            waits++;
        end
        if (waits >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL opv_timeout: op_valid never rose within 40 cycles");
        end
    endtask

    initial begin
        int w;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Two-operand read with rd=7 locked.
        do_decode(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, w);
        chk32("t1_accept_wait", w, 0);
        @(negedge clk); chk1("t1_en_r_n1", rf_en_r_o, 1'b0);
        @(negedge clk); chk1("t1_en_r_n2", rf_en_r_o, 1'b1);
        @(negedge clk); chk1("t1_opv_n3", op_valid_o, 1'b1);
        chk32("t1_op_a", op_a_o, 32'h11);
        chk32("t1_op_b", op_b_o, 32'h22);
        tick();

        // RAW on x7 stalls until the ALU writeback clears the lock.
        dec_ra = 5'd7; dec_ua = 1'b1; dec_rb = 5'd0; dec_ub = 1'b0; dec_we = 1'b0;
        dec_valid = 1'b1;
        @(negedge clk); chk1("t2_blocked", dec_ready_o, 1'b0);
        tick();
        do_wb(5'd7, 1'b1, 32'h0000_ABCD, 1'b1, w);
        chk32("t2_wb_latency", w, 2);
        @(negedge clk); chk1("t2_ready_after", dec_ready_o, 1'b1);
        tick();
        dec_valid = 1'b0;
        wait_opv(w);
        chk32("t2_op_a", op_a_o, 32'h0000_ABCD);
        tick();

        // Writeback and decode presented together: writeback first.
        dec_ra = 5'd3; dec_ua = 1'b1; dec_rb = 5'd0; dec_ub = 1'b0; dec_we = 1'b0;
        dec_valid = 1'b1;
        do_wb(5'd3, 1'b0, 32'h0000_0033, 1'b1, w);
        chk32("t3_wb_latency", w, 2);
        @(negedge clk); chk1("t3_ready_after", dec_ready_o, 1'b1);
        tick();
        dec_valid = 1'b0;
        wait_opv(w);
        chk32("t3_op_a", op_a_o, 32'h0000_0033);
        tick();

        // x0 reads as zero; LSU writeback to x0 handshakes without writing.
        do_decode(5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, w);
        wait_opv(w);
        chk32("t4_op_a_x0", op_a_o, 32'h0);
        chk32("t4_op_b", op_b_o, 32'h11);
        tick();
        do_wb(5'd0, 1'b0, 32'h0000_0055, 1'b0, w);
        chk32("t4_wb_latency", w, 2);
        chk32("t4_mem0", mem[0], 32'hFFFF_FFFF);

        // Consumer back-pressure for 5 cycles.
        op_ready = 1'b0;
        do_decode(5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, w);
        wait_opv(w);
        for (int i = 0; i < 5; i++) begin
            chk1("t5_opv", op_valid_o, 1'b1);
            chk32("t5_op_a", op_a_o, 32'h22);
            chk32("t5_op_b", op_b_o, 32'h11);
            chk1("t5_no_en_r", rf_en_r_o, 1'b0);
            chk1("t5_no_en_w", rf_en_w_o, 1'b0);
            @(negedge clk);
        end
        tick();
        op_ready = 1'b1;
        tick();
        tick();

        // Reset in the middle of the read strobe.
        do_decode(5'd6, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, w);
        tick();
        chk1("t6_en_r_before", rf_en_r_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("t6_en_r_drop", rf_en_r_o, 1'b0);
        chk1("t6_opv_drop", op_valid_o, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_decode(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, w);
        chk32("t6_lock_cleared", w, 0);
        wait_opv(w);
        chk32("t6_op_a", op_a_o, 32'h0909_0909);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
